video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator and pixel output
// stage. Produces sync/blank timing, pixel coordinate requests for the
// frame-buffer readers, and selects output pixels from N prioritised
// source channels or an internal test pattern.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   mode                00 pass-through, 01 colour bars, 10 fill, 11 grid
//   fill_rgb            solid-fill colour {r,g,b}
//   in_da_en            per-channel valid, bit 0 highest priority
//   in_da_rgb           channel k at [(k+1)*3*DW-1 : k*3*DW], {r,g,b}
//   h_c, v_c, h_c_en    requested pixel coordinate and its valid
//   frame_start         pulse with the first output pixel of a frame
//   out_hsync/vsync/de  output timing, aligned with the RGB outputs
//   out_da_r/g/b        output pixel, 0 outside the active region
module video_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int N_CH     = 4,
    parameter int DW       = 8,
    parameter int RD_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    mode,
    input  logic [3*DW-1:0]               fill_rgb,
    input  logic [N_CH-1:0]               in_da_en,
    input  logic [N_CH*3*DW-1:0]          in_da_rgb,
    output logic [$clog2(H_ACTIVE)-1:0]   h_c,
    output logic [$clog2(V_ACTIVE)-1:0]   v_c,
    output logic                          h_c_en,
    output logic                          frame_start,
    output logic                          out_hsync,
    output logic                          out_vsync,
    output logic                          out_de,
    output logic [DW-1:0]                 out_da_r,
    output logic [DW-1:0]                 out_da_g,
    output logic [DW-1:0]                 out_da_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int HW      = $clog2(H_ACTIVE);
    localparam int VW      = $clog2(V_ACTIVE);
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int BPW     = $clog2(BAR_W + 1);
    localparam int PW      = 3 * DW;

    // One pixel's worth of timing and coordinate state, carried down the
    // read-latency delay line so it meets the returning channel data.
    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          fs;
        logic [2:0]    bar;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
    } stage_t;

    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic [31:0]    hx, vx;
    logic           active, hs_act, vs_act, frame_org;

    logic [BPW-1:0] bpx_q, bpx_d;
    logic [2:0]     bar_d;
    logic [1:0]     mode_q, mode_d;

    stage_t         st_rst, st_d, samp;
    stage_t         pipe_q [RD_LAT+1];

    logic [PW-1:0]  ch_pix, pix;
    logic           grid_on;

    logic           de_q, hs_q, vs_q, fs_q;
    logic [PW-1:0]  rgb_q;

    assign hx = 32'(hcnt_q);
    assign vx = 32'(vcnt_q);

    assign active    = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
    assign hs_act    = (hx >= 32'(H_ACTIVE + H_FP)) &&
                       (hx <  32'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_act    = (vx >= 32'(V_ACTIVE + V_FP)) &&
                       (vx <  32'(V_ACTIVE + V_FP + V_SYNC));
    assign frame_org = (hx == 32'd0) && (vx == 32'd0);

    always_comb begin
        hcnt_d = hcnt_q + HCW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == HCW'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == VCW'(V_TOTAL - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VCW'(1);
            end
        end
    end

    // Mode is only picked up at the frame origin so a frame never mixes
    // two sources.
    always_comb begin
        mode_d = mode_q;
        if (frame_org) begin
            mode_d = mode;
        end
    end

    // Bar index counts whole bar widths along the line and sticks at the
    // last bar for any remainder pixels.
    always_comb begin
        bar_d = pipe_q[0].bar;
        bpx_d = bpx_q;
        if (active) begin
            if (hx == 32'd0) begin
                bar_d = 3'd0;
                bpx_d = '0;
            end else if (bpx_q == BPW'(BAR_W - 1)) begin
                bpx_d = '0;
                if (pipe_q[0].bar != 3'd7) begin
                    bar_d = pipe_q[0].bar + 3'd1;
                end
            end else begin
                bpx_d = bpx_q + BPW'(1);
            end
        end
    end

    always_comb begin
        st_rst    = '0;
        st_rst.hs = ~HS_POL;
        st_rst.vs = ~VS_POL;
    end

    always_comb begin
        st_d     = pipe_q[0];
        st_d.de  = active;
        st_d.hs  = hs_act ? HS_POL : ~HS_POL;
        st_d.vs  = vs_act ? VS_POL : ~VS_POL;
        st_d.fs  = active && frame_org;
        st_d.bar = bar_d;
        if (active) begin
            st_d.h = HW'(hcnt_q);
            st_d.v = VW'(vcnt_q);
        end
    end

    assign samp = pipe_q[RD_LAT];

    // Scanning from the top index down leaves the lowest enabled channel
    // as the final assignment; with none enabled the top channel stays.
    always_comb begin
        ch_pix = in_da_rgb[(N_CH-1)*PW +: PW];
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (in_da_en[k]) begin
                ch_pix = in_da_rgb[k*PW +: PW];
            end
        end
    end

    assign grid_on = ((32'(samp.h) % 32'd16) == 32'd0) ||
                     ((32'(samp.v) % 32'd16) == 32'd0);

    always_comb begin
        pix = '0;
        unique case (mode_q)
            2'b00: pix = ch_pix;
            2'b01: pix = {{DW{~samp.bar[1]}},
                          {DW{~samp.bar[2]}},
                          {DW{~samp.bar[0]}}};
            2'b10: pix = fill_rgb;
            2'b11: pix = grid_on ? {PW{1'b1}} : '0;
            default: pix = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            bpx_q  <= '0;
            mode_q <= 2'b00;
            for (int k = 0; k <= RD_LAT; k++) begin
                pipe_q[k] <= st_rst;
            end
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            fs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            bpx_q     <= bpx_d;
            mode_q    <= mode_d;
            pipe_q[0] <= st_d;
            for (int k = 1; k <= RD_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
            de_q  <= samp.de;
            hs_q  <= samp.hs;
            vs_q  <= samp.vs;
            fs_q  <= samp.fs;
            rgb_q <= samp.de ? pix : '0;
        end
    end

    assign h_c         = pipe_q[0].h;
    assign v_c         = pipe_q[0].v;
    assign h_c_en      = pipe_q[0].de;
    assign frame_start = fs_q;
    assign out_hsync   = hs_q;
    assign out_vsync   = vs_q;
    assign out_de      = de_q;
    assign out_da_r    = rgb_q[3*DW-1:2*DW];
    assign out_da_g    = rgb_q[2*DW-1:DW];
    assign out_da_b    = rgb_q[DW-1:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized bench for video_timing_gen against a
// position-based raster model, using a reduced frame geometry.
module tb_video_timing_gen;

    localparam int HA   = 45;
    localparam int HFP  = 3;
    localparam int HSW  = 4;
    localparam int HBP  = 5;
    localparam int VA   = 20;
    localparam int VFP  = 1;
    localparam int VSW  = 2;
    localparam int VBP  = 3;
    localparam bit HP   = 1'b0;
    localparam bit VP   = 1'b1;
    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int HT   = HA + HFP + HSW + HBP;
    localparam int VT   = VA + VFP + VSW + VBP;
    localparam int FT   = HT * VT;
    localparam int BARW = HA / 8;
    localparam int HW   = $clog2(HA);
    localparam int VW   = $clog2(VA);
    localparam int NCYC = 13 * FT;
    localparam int RST_POS = 6 * FT + 10 * HT + 30;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      mode;
    logic [23:0]     fill;
    logic [NCH-1:0]  en;
    logic [NCH*24-1:0] rgb;
    logic [HW-1:0]   h_c;
    logic [VW-1:0]   v_c;
    logic            h_c_en, frame_start, out_hsync, out_vsync, out_de;
    logic [DW-1:0]   out_da_r, out_da_g, out_da_b;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HP), .VS_POL(VP), .N_CH(NCH), .DW(DW), .RD_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .fill_rgb(fill),
        .in_da_en(en), .in_da_rgb(rgb),
        .h_c(h_c), .v_c(v_c), .h_c_en(h_c_en),
        .frame_start(frame_start), .out_hsync(out_hsync),
        .out_vsync(out_vsync), .out_de(out_de),
        .out_da_r(out_da_r), .out_da_g(out_da_g), .out_da_b(out_da_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit act(int p);
        return ((p % HT) < HA) && (((p / HT) % VT) < VA);
    endfunction

    function automatic logic [23:0] bar_rgb(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [3:0] ref_sync(int q);
        int h, v;
        logic d, hs, vs, fs;
        h  = q % HT;
        v  = (q / HT) % VT;
        d  = act(q);
        hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HP : ~HP;
        vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VP : ~VP;
        fs = (h == 0) && (v == 0);
        return {d, hs, vs, fs};
    endfunction

    function automatic logic [23:0] ref_pix(int q, logic [1:0] md,
                                            logic [NCH-1:0] e,
                                            logic [NCH*24-1:0] d,
                                            logic [23:0] f);
        int h, v, sel, idx;
        h = q % HT;
        v = (q / HT) % VT;
        if (!act(q)) return 24'h0;
        case (md)
            2'd0: begin
                sel = NCH - 1;
                for (int i = 0; i < NCH; i++) begin
                    if (e[i]) begin
                        sel = i;
                        break;
                    end
                end
                return d[sel*24 +: 24];
            end
            2'd1: begin
                idx = h / BARW;
                if (idx > 7) idx = 7;
                return bar_rgb(idx);
            end
            2'd2: return f;
            default: return ((h % 16 == 0) || (v % 16 == 0)) ?
                            24'hFFFFFF : 24'h0;
        endcase
    endfunction

    int              pos, last_h, last_v, de_cnt, k, q;
    bit              have_fs, did_rst, e_en;
    logic [1:0]      nxt;
    logic [1:0]      fmode [64];
    logic [NCH-1:0]  p_en;
    logic [NCH*24-1:0] p_rgb;
    logic [23:0]     p_fill, e_pix;
    logic [3:0]      e_sync;

    initial begin
        rst  = 1'b1;
        mode = 2'b00;
        fill = 24'h0;
        en   = '0;
        rgb  = '0;
        p_en = '0;
        p_rgb = '0;
        p_fill = '0;
        for (int i = 0; i < 64; i++) fmode[i] = 2'b00;
        repeat (2) @(posedge clk);
        pos = 0;
        last_h = 0;
        last_v = 0;
        nxt = 2'd1;
        de_cnt = 0;
        have_fs = 1'b0;
        did_rst = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            k = pos;
            e_en = (k > 0) && act(k - 1);
            check("coord", {h_c_en, h_c, v_c},
                  {e_en, HW'(last_h), VW'(last_v)});
            q = k - LAT - 2;
            if (q >= 0) begin
                e_sync = ref_sync(q);
                e_pix  = ref_pix(q, fmode[q / FT], p_en, p_rgb, p_fill);
            end else begin
                e_sync = {1'b0, ~HP, ~VP, 1'b0};
                e_pix  = 24'h0;
            end
            check("sync", {out_de, out_hsync, out_vsync, frame_start},
                  e_sync);
            check("rgb", {out_da_r, out_da_g, out_da_b}, e_pix);

            if (frame_start) begin
                if (have_fs) check("frame_px", 64'(de_cnt), 64'(HA * VA));
                have_fs = 1'b1;
                de_cnt = 0;
            end
            if (out_de) de_cnt++;

            if (!did_rst && pos == RST_POS) begin
                rst = 1'b1;
                did_rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            if (!rst && (pos % FT == FT / 2)) begin
                mode = nxt;
                nxt = nxt + 2'd1;
            end
            en  = NCH'($urandom);
            rgb = {$urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 63) == 0) fill = 24'($urandom);

            if (rst) begin
                pos = 0;
                last_h = 0;
                last_v = 0;
                have_fs = 1'b0;
            end else begin
                if (pos % FT == 0) fmode[pos / FT] = mode;
                if (act(pos)) begin
                    last_h = pos % HT;
                    last_v = (pos / HT) % VT;
                end
                pos++;
            end
            p_en   = en;
            p_rgb  = rgb;
            p_fill = fill;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
